// File: rtl/frogger_pkg.sv
// Shared frogger types and screen constants.
package frogger_pkg;

    localparam int SCREEN_X_MAX = 639;
    localparam int FROG_W       = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RIDING  = 2'd1,
        GRACE   = 2'd2,
        DROWNED = 2'd3
    } carrier_state_t;

    // A row speed of zero still moves the frog, one pixel every frame.
    function automatic logic [5:0] effective_speed(input logic [5:0] speed);
        return (speed == 6'd0) ? 6'd1 : speed;
    endfunction

endpackage

// File: rtl/frog_carrier_frame_tick.sv
// frame_tick: turns the vsync frame strobe into a one-Clk tick on its rising edge.
module frame_tick (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic frame_q;

    // Remember last sampled strobe level for edge detection.
    always_ff @(posedge Clk) begin
        if (!Reset)
            frame_q <= 1'b0;
        else
            frame_q <= frame_clk;
    end

    assign tick = frame_clk & ~frame_q;

endmodule

// File: rtl/frog_carrier.sv
// frog_carrier: carries a frog along a river row while it sits on a lilypad,
// and runs the drown / death-hold / respawn sequence when it loses support.
// Build option: define FROG_CARRIER_GRACE_EN to allow GRACE_FRAMES frames of
// unsupported floating before drowning; undefined, losing support drowns at once.
module frog_carrier
    import frogger_pkg::*;
#(
    parameter int FROG_WIDTH   = FROG_W,
    parameter int X_MAX        = SCREEN_X_MAX,
    parameter int GRACE_FRAMES = 4,
    parameter int DEATH_FRAMES = 60
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        In_River,
    input  logic        Hop_Active,
    input  logic        LPad_Collision,
    input  logic [5:0]  Speed,
    input  logic        Direction,
    input  logic [10:0] Frog_X,
    output logic [10:0] Frog_X_Out,
    output logic        Carry_Valid,
    output logic        Drown,
    output logic        Dead,
    output logic        Respawn
);

    localparam logic [10:0] X_LIM = 11'(X_MAX - FROG_WIDTH + 1);
    localparam int DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES + 1) : 1;

    carrier_state_t state;
    logic [5:0]     step_cnt;
    logic [DW-1:0]  death_cnt;
    logic           tick;
    logic           active;
    logic           step_due;
    logic           at_limit;
    logic           drown_req;

`ifdef FROG_CARRIER_GRACE_EN
    localparam int GW = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES + 1) : 1;
    logic [GW-1:0] grace_cnt;
    logic [GW-1:0] grace_nxt;
`endif

    frame_tick u_frame_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // Decode whether this tick kills the frog, before the state register acts on it.
    always_comb begin
        active    = tick && (state != DROWNED) && In_River && !Hop_Active;
        step_due  = (step_cnt >= (effective_speed(Speed) - 6'd1));
        at_limit  = Direction ? (Frog_X >= X_LIM) : (Frog_X == 11'd0);
        drown_req = 1'b0;
`ifdef FROG_CARRIER_GRACE_EN
        grace_nxt = grace_cnt + 1'b1;
`endif
        if (active) begin
            case (state)
`ifdef FROG_CARRIER_GRACE_EN
                RIDING:  drown_req = LPad_Collision && step_due && at_limit;
                // Entry tick counts as the first unsupported frame, so the
                // counter reaching GRACE_FRAMES-1 is the GRACE_FRAMES-th one.
                GRACE:   drown_req = !LPad_Collision &&
                                     (grace_nxt >= GW'(GRACE_FRAMES - 1));
                default: drown_req = 1'b0;
`else
                IDLE:    drown_req = !LPad_Collision;
                RIDING:  drown_req = !LPad_Collision || (step_due && at_limit);
                default: drown_req = 1'b0;
`endif
            endcase
        end
    end

    // Carrier FSM with registered outputs; state only moves on frame ticks.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= IDLE;
            step_cnt    <= '0;
            death_cnt   <= '0;
`ifdef FROG_CARRIER_GRACE_EN
            grace_cnt   <= '0;
`endif
            Frog_X_Out  <= '0;
            Carry_Valid <= 1'b0;
            Drown       <= 1'b0;
            Dead        <= 1'b0;
            Respawn     <= 1'b0;
        end else begin
            Carry_Valid <= 1'b0;
            Drown       <= 1'b0;
            Respawn     <= 1'b0;
            Frog_X_Out  <= Frog_X;
            if (drown_req) begin
                state     <= DROWNED;
                Drown     <= 1'b1;
                Dead      <= 1'b1;
                death_cnt <= '0;
                step_cnt  <= '0;
`ifdef FROG_CARRIER_GRACE_EN
                grace_cnt <= '0;
`endif
                if (Frog_X > X_LIM)
                    Frog_X_Out <= X_LIM;
            end else if (tick) begin
                if (state == DROWNED) begin
                    if (death_cnt == DW'(DEATH_FRAMES - 1)) begin
                        state     <= IDLE;
                        Dead      <= 1'b0;
                        Respawn   <= 1'b1;
                        death_cnt <= '0;
                    end else begin
                        death_cnt <= death_cnt + 1'b1;
                    end
                end else if (!In_River) begin
                    state    <= IDLE;
                    step_cnt <= '0;
`ifdef FROG_CARRIER_GRACE_EN
                    grace_cnt <= '0;
`endif
                end else if (!Hop_Active) begin
                    case (state)
                        IDLE: begin
                            if (LPad_Collision) begin
                                state    <= RIDING;
                                step_cnt <= '0;
                            end
`ifdef FROG_CARRIER_GRACE_EN
                            else begin
                                state     <= GRACE;
                                grace_cnt <= '0;
                            end
`endif
                        end
                        RIDING: begin
                            if (!LPad_Collision) begin
`ifdef FROG_CARRIER_GRACE_EN
                                state     <= GRACE;
                                grace_cnt <= '0;
`endif
                            end else if (step_due) begin
                                step_cnt    <= '0;
                                Carry_Valid <= 1'b1;
                                Frog_X_Out  <= Direction ? (Frog_X + 11'd1)
                                                         : (Frog_X - 11'd1);
                            end else begin
                                step_cnt <= step_cnt + 6'd1;
                            end
                        end
`ifdef FROG_CARRIER_GRACE_EN
                        GRACE: begin
                            if (LPad_Collision)
                                state <= RIDING;
                            else
                                grace_cnt <= grace_nxt;
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_frog_carrier.sv
// Directed bench for frog_carrier with hand-computed expectations.
// Follows FROG_CARRIER_GRACE_EN the same way the design does.
module tb_frog_carrier;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        In_River;
    logic        Hop_Active;
    logic        LPad_Collision;
    logic [5:0]  Speed;
    logic        Direction;
    logic [10:0] Frog_X;
    logic [10:0] Frog_X_Out;
    logic        Carry_Valid;
    logic        Drown;
    logic        Dead;
    logic        Respawn;

    int n_checks = 0;
    int n_fails  = 0;

    logic        cv, dr, dd, rs;
    logic [10:0] xo;

    frog_carrier #(
        .FROG_WIDTH   (32),
        .X_MAX        (639),
        .GRACE_FRAMES (4),
        .DEATH_FRAMES (60)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .In_River       (In_River),
        .Hop_Active     (Hop_Active),
        .LPad_Collision (LPad_Collision),
        .Speed          (Speed),
        .Direction      (Direction),
        .Frog_X         (Frog_X),
        .Frog_X_Out     (Frog_X_Out),
        .Carry_Valid    (Carry_Valid),
        .Drown          (Drown),
        .Dead           (Dead),
        .Respawn        (Respawn)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required test end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // One frame tick; outputs are captured just after the edge that saw it.
    task automatic do_tick();
        @(negedge Clk);
        frame_clk = 1'b1;
        @(posedge Clk);
        #1;
        cv = Carry_Valid; dr = Drown; dd = Dead; rs = Respawn; xo = Frog_X_Out;
        @(negedge Clk);
        frame_clk = 1'b0;
    endtask

    int drowns;
    int respawns;
    int carries;

    initial begin
        Reset = 1'b0; frame_clk = 1'b0; In_River = 1'b0; Hop_Active = 1'b0;
        LPad_Collision = 1'b0; Speed = 6'd3; Direction = 1'b1; Frog_X = 11'd100;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst_x", 32'(Frog_X_Out), 32'd0);
        check("rst_cv", 32'(Carry_Valid), 32'd0);
        check("rst_dead", 32'(Dead), 32'd0);
        check("rst_rs", 32'(Respawn), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("follow_x", 32'(Frog_X_Out), 32'd100);

        // Riding at Speed=3 to the right: carry every 3rd tick
        In_River = 1'b1; LPad_Collision = 1'b1;
        do_tick();
        check("enter_ride_cv", 32'(cv), 32'd0);
        for (int k = 0; k < 3; k++) begin
            do_tick();
            check("ride_t1_cv", 32'(cv), 32'd0);
            do_tick();
            check("ride_t2_cv", 32'(cv), 32'd0);
            do_tick();
            check("ride_t3_cv", 32'(cv), 32'd1);
            check("ride_x", 32'(xo), 32'(101 + k));
            Frog_X = xo;
            @(posedge Clk);
            #1;
            check("cv_pulse_end", 32'(Carry_Valid), 32'd0);
        end

        // Hop freezes the step counter: advance to 1, hop 10 unsupported ticks,
        // then the carry must come on the 2nd supported tick.
        do_tick();
        check("pre_hop_cv", 32'(cv), 32'd0);
        Hop_Active = 1'b1; LPad_Collision = 1'b0;
        drowns = 0; carries = 0;
        for (int k = 0; k < 10; k++) begin
            do_tick();
            drowns  += int'(dr);
            carries += int'(cv);
        end
        check("hop_drowns", 32'(drowns), 32'd0);
        check("hop_carries", 32'(carries), 32'd0);
        check("hop_dead", 32'(dd), 32'd0);
        Hop_Active = 1'b0; LPad_Collision = 1'b1;
        do_tick();
        check("post_hop_t1_cv", 32'(cv), 32'd0);
        do_tick();
        check("post_hop_t2_cv", 32'(cv), 32'd1);
        check("post_hop_x", 32'(xo), 32'd104);
        Frog_X = 11'd104;

`ifdef FROG_CARRIER_GRACE_EN
        // Three unsupported ticks then the pad returns: survive, resume riding
        LPad_Collision = 1'b0;
        drowns = 0;
        for (int k = 0; k < 3; k++) begin
            do_tick();
            drowns += int'(dr);
        end
        check("grace3_drowns", 32'(drowns), 32'd0);
        LPad_Collision = 1'b1;
        do_tick();
        check("regain_cv", 32'(cv), 32'd0);
        check("regain_dr", 32'(dr), 32'd0);
        do_tick();
        do_tick();
        check("regain_t2_cv", 32'(cv), 32'd0);
        do_tick();
        check("regain_t3_cv", 32'(cv), 32'd1);
        check("regain_x", 32'(xo), 32'd105);
        Frog_X = 11'd105;

        // Four unsupported ticks: drown on the 4th
        LPad_Collision = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_tick();
            check("grace_no_drown", 32'(dr), 32'd0);
        end
        do_tick();
`else
        // Without the grace window the first unsupported tick drowns
        LPad_Collision = 1'b0;
        do_tick();
`endif
        check("drown_pulse", 32'(dr), 32'd1);
        check("drown_dead", 32'(dd), 32'd1);
        @(posedge Clk);
        #1;
        check("drown_pulse_end", 32'(Drown), 32'd0);
        check("dead_level", 32'(Dead), 32'd1);

        // Death hold ignores inputs; Respawn on the 60th tick
        LPad_Collision = 1'b1;
        respawns = 0; carries = 0;
        for (int k = 0; k < 59; k++) begin
            do_tick();
            respawns += int'(rs);
            carries  += int'(cv);
        end
        check("hold_respawns", 32'(respawns), 32'd0);
        check("hold_carries", 32'(carries), 32'd0);
        check("hold_dead", 32'(dd), 32'd1);
        do_tick();
        check("respawn_pulse", 32'(rs), 32'd1);
        check("respawn_dead", 32'(dd), 32'd0);
        @(posedge Clk);
        #1;
        check("respawn_end", 32'(Respawn), 32'd0);

        // Speed=0 acts as 1; right clamp at 608 drowns
        Direction = 1'b1; Speed = 6'd0; Frog_X = 11'd607;
        do_tick();
        check("s0_enter_cv", 32'(cv), 32'd0);
        do_tick();
        check("s0_cv", 32'(cv), 32'd1);
        check("s0_x", 32'(xo), 32'd608);
        Frog_X = 11'd608;
        do_tick();
        check("rclamp_dr", 32'(dr), 32'd1);
        check("rclamp_cv", 32'(cv), 32'd0);
        check("rclamp_x", 32'(xo), 32'd608);

        // Reset in the death hold: outputs clear, no Respawn afterwards
        do_tick();
        do_tick();
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("midrst_dead", 32'(Dead), 32'd0);
        check("midrst_x", 32'(Frog_X_Out), 32'd0);
        check("midrst_rs", 32'(Respawn), 32'd0);
        check("midrst_dr", 32'(Drown), 32'd0);
        @(negedge Clk);
        Reset = 1'b1; In_River = 1'b0;
        respawns = 0;
        for (int k = 0; k < 62; k++) begin
            do_tick();
            respawns += int'(rs);
        end
        check("midrst_no_respawn", 32'(respawns), 32'd0);

        // Left riding: 1 -> 0, then stepping at 0 drowns with X held at 0
        In_River = 1'b1; LPad_Collision = 1'b1; Direction = 1'b0; Speed = 6'd1;
        Frog_X = 11'd1;
        do_tick();
        do_tick();
        check("left_cv", 32'(cv), 32'd1);
        check("left_x", 32'(xo), 32'd0);
        Frog_X = 11'd0;
        do_tick();
        check("lclamp_dr", 32'(dr), 32'd1);
        check("lclamp_cv", 32'(cv), 32'd0);
        check("lclamp_x", 32'(xo), 32'd0);
        check("lclamp_dead", 32'(dd), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/frog_carrier.md
FROG_CARRIER -- requirements
Module: frog_carrier

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- FROG_WIDTH, 32, frog sprite width in px.
- X_MAX, 639, rightmost screen column.
- GRACE_FRAMES, 4, frames unsupported before drowning.
- DEATH_FRAMES, 60, frames held dead before respawn.
REQ-002 SHALL have ports (name direction width meaning):
- Clk in 1 system clock; the block's one clock.
- Reset in 1 synchronous, active-low reset.
- frame_clk in 1 vertical-sync frame strobe, sampled in Clk.
- In_River in 1 frog is in a water row.
- Hop_Active in 1 frog is mid-hop.
- LPad_Collision in 1 frog overlaps a visible lilypad of its row.
- Speed in 6 row speed: frames per 1-px step.
- Direction in 1 1 = right, 0 = left.
- Frog_X in 11 current frog X.
- Frog_X_Out out 11 carried frog X.
- Carry_Valid out 1 one-Clk pulse: Frog_X_Out updated.
- Drown out 1 one-Clk pulse on death.
- Dead out 1 level, high while dead.
- Respawn out 1 one-Clk pulse at end of death hold.

Function
REQ-003 SHALL detect a frame tick as a rising edge of frame_clk registered in Clk; all state advances only on frame ticks.
REQ-004 SHALL implement states IDLE, RIDING, GRACE, DROWNED.
REQ-005 From IDLE: In_River=1, Hop_Active=0, LPad_Collision=1 -> RIDING; In_River=1, Hop_Active=0, LPad_Collision=0 -> GRACE.
REQ-006 In any state other than DROWNED: In_River=0 -> IDLE and the step counter clears.
REQ-007 While Hop_Active=1, SHALL hold state, grace counter and step counter; no carry, no drown.
REQ-008 In RIDING, the step counter increments each tick; when it reaches Speed-1, it clears and Frog_X_Out = Frog_X+1 (Direction=1) or Frog_X-1 (Direction=0), with Carry_Valid pulsed.
REQ-009 Speed=0 SHALL be treated as 1, giving one step every tick.
REQ-010 Carry SHALL clamp Frog_X_Out to [0, X_MAX-FROG_WIDTH+1]; a step requested while already at a clamp limit SHALL cause the drown sequence.
REQ-011 In RIDING, LPad_Collision=0 SHALL move to GRACE and load the grace counter to 0.
REQ-012 In GRACE: LPad_Collision=1 -> RIDING; otherwise the counter increments, and reaching GRACE_FRAMES triggers the drown sequence.
REQ-013 Drown sequence: pulse Drown for one Clk, set Dead=1, enter DROWNED, clear the death counter.
REQ-014 DROWNED SHALL ignore all inputs; after DEATH_FRAMES ticks it SHALL pulse Respawn, clear Dead, and return to IDLE.
REQ-015 When no carry occurs, Frog_X_Out SHALL follow Frog_X registered each Clk.
REQ-016 If a tick and a collision loss coincide in RIDING, the collision loss SHALL win: move to GRACE with no step that tick.

Reset
REQ-017 Reset=0 at a Clk edge SHALL set:
- state IDLE;
- all counters 0;
- Frog_X_Out=0, Carry_Valid=0, Drown=0, Dead=0, Respawn=0;
- the edge-detect register 0.
REQ-018 Reset mid-DROWNED SHALL abort the hold without a Respawn pulse.

Configuration
REQ-019 Macro FROG_CARRIER_GRACE_EN SHALL control the grace window:
- Defined: GRACE state is used as specified above.
- Undefined: GRACE is removed, and any unsupported in-river tick triggers the drown sequence immediately.

Structure
REQ-020 Package frogger_pkg SHALL hold the carrier_state_t enum and the constants SCREEN_X_MAX=639 and FROG_W=32.
REQ-021 Frame-edge detection SHALL be the sub-module frame_tick (inputs Clk, Reset, frame_clk; output tick).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Speed=3, Direction=1, riding, Frog_X=100 -> Carry_Valid every 3rd tick; Frog_X_Out 101, 102, 103.
- Riding, LPad_Collision drops for 3 ticks then returns (GRACE_EN, GRACE_FRAMES=4) -> no Drown, back to RIDING.
- LPad_Collision=0 for 4 ticks -> one Drown pulse, Dead=1; after 60 ticks Respawn pulses and Dead=0.
- Direction=0, Frog_X=0, riding, Speed=1 -> Frog_X_Out stays 0, Drown on that tick.
- Hop_Active=1 over water with no lilypad for 10 ticks -> no Drown, counters frozen.
- Reset=0 during DROWNED -> outputs zero next Clk, no Respawn pulse.
